dfconv_dispatch: RTL and testbench
==================================

DFCONV_DISPATCH -- requirements
Module: dfconv_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the bit width of each layer dimension field.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, the bit width of cycle counts and accumulators.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the number of descriptor queue entries; it is a power of 2 and at least 2.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port desc_valid  input  1  a layer descriptor is offered.
REQ-007 SHALL have port desc_ready  output  1  the queue can accept a descriptor; equals !full.
REQ-008 SHALL have ports desc_rows, desc_cols, desc_in_ch, desc_out_ch  input  WIDTH each  the descriptor fields.
REQ-009 SHALL have port dfc_start  output  1  one-cycle launch pulse to the downstream dfconv.
REQ-010 SHALL have ports dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch  output  WIDTH each  registered fields of the active job.
REQ-011 SHALL have port dfc_done  input  1  completion pulse from dfconv.
REQ-012 SHALL have port dfc_cycles_used  input  ACC_WIDTH  cycle count reported by dfconv; valid when dfc_done is high.
REQ-013 SHALL have port stat_clr  input  1  synchronous clear of the statistics.
REQ-014 SHALL have port total_cycles  output  ACC_WIDTH  saturating sum of dfc_cycles_used.
REQ-015 SHALL have port jobs_done  output  WIDTH  count of completed jobs; wraps modulo 2^WIDTH.
REQ-016 SHALL have port idle  output  1  high when the FSM is in IDLE and the queue is empty.

Function
REQ-017 SHALL accept a descriptor on a rising edge where desc_valid and desc_ready are both high; descriptors are dispatched in FIFO order.
REQ-018 SHALL block pushes when the queue is full, even if a pop occurs in the same cycle.
REQ-019 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> IDLE.
REQ-020 In IDLE with the queue non-empty, SHALL pop the head entry into the dfc_* registers and enter LAUNCH.
REQ-021 SHALL drive dfc_start high for exactly the one cycle spent in LAUNCH, then enter WAIT.
REQ-022 In WAIT, on dfc_done, SHALL add dfc_cycles_used to total_cycles (saturating at all-ones), increment jobs_done, and return to IDLE.
REQ-023 SHALL ignore dfc_done outside WAIT.
REQ-024 SHALL keep dfc_rows, dfc_cols, dfc_in_ch and dfc_out_ch stable from LAUNCH until the next pop.
REQ-025 With the queue empty and the FSM in IDLE, a descriptor accepted at edge N SHALL give dfc_start high in the cycle following edge N+1.
REQ-026 If stat_clr and an accumulation coincide, SHALL clear first and then apply the accumulation (total_cycles = dfc_cycles_used, jobs_done = 1).

Reset
REQ-027 On rst_n low, SHALL immediately empty the queue, set the FSM to IDLE, and zero dfc_start, dfc_* fields, total_cycles and jobs_done; desc_ready returns to 1 and idle to 1.
REQ-028 Reset during WAIT SHALL drop the outstanding job; a later dfc_done is ignored.

Configuration
REQ-029 With DFCONV_DISPATCH_ZERO_SKIP_EN defined, SHALL retire a popped descriptor that has any zero field without pulsing dfc_start: jobs_done increments, total_cycles is unchanged, and the FSM goes IDLE -> IDLE in one cycle.
REQ-030 Without DFCONV_DISPATCH_ZERO_SKIP_EN, SHALL dispatch zero-field descriptors like any other descriptor.

Verification
REQ-031 Bench SHALL drive a single descriptor (4,4,36,36) with dfconv cost 761 -> exactly one dfc_start pulse; total_cycles=761, jobs_done=1, idle=1.
REQ-032 Bench SHALL back-to-back push (4,4,36,36), (8,8,36,36), (4,16,36,36) -> three in-order launches; total_cycles=6849, jobs_done=3.
REQ-033 Bench SHALL push 5 descriptors with dfconv stalled and FIFO_DEPTH=4 -> desc_ready=0 once 4 are queued and 1 is active; all 5 complete in order.
REQ-034 Bench SHALL preload total_cycles=0xFFFFFFF0, then complete a job of cost 761 -> total_cycles=0xFFFFFFFF.
REQ-035 Bench SHALL assert stat_clr on the same cycle as dfc_done for the (1,1,1,1) job of cost 3 -> total_cycles=3, jobs_done=1; a separate run SHALL apply reset in WAIT -> all outputs zero and a late dfc_done ignored.
REQ-036 Bench SHALL push descriptor (0,4,36,36) -> with the macro defined, no dfc_start and jobs_done=1; without it, one dfc_start pulse.

Source files
------------

// File: rtl/dfconv_dispatch.sv
// dfconv_dispatch: queues layer descriptors and launches them one at a time on a dfconv engine, accumulating cycle statistics. Optional macro DFCONV_DISPATCH_ZERO_SKIP_EN retires zero-field descriptors without launching.
module dfconv_dispatch #(
  parameter int WIDTH      = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [WIDTH-1:0]     desc_rows,
  input  logic [WIDTH-1:0]     desc_cols,
  input  logic [WIDTH-1:0]     desc_in_ch,
  input  logic [WIDTH-1:0]     desc_out_ch,
  output logic                 dfc_start,
  output logic [WIDTH-1:0]     dfc_rows,
  output logic [WIDTH-1:0]     dfc_cols,
  output logic [WIDTH-1:0]     dfc_in_ch,
  output logic [WIDTH-1:0]     dfc_out_ch,
  input  logic                 dfc_done,
  input  logic [ACC_WIDTH-1:0] dfc_cycles_used,
  input  logic                 stat_clr,
  output logic [ACC_WIDTH-1:0] total_cycles,
  output logic [WIDTH-1:0]     jobs_done,
  output logic                 idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t               state, state_nx;
  logic [4*WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push, pop, skip, acc;
  logic [4*WIDTH-1:0]   head;
  logic [ACC_WIDTH-1:0] tot_base;
  logic [WIDTH-1:0]     jobs_base;
  logic [ACC_WIDTH:0]   sum;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign desc_ready = !full;
  assign push       = desc_valid && !full;
  assign pop        = state == IDLE && !empty;
  assign head       = mem[rd_ptr[PW-1:0]];
  assign acc        = state == WAIT && dfc_done;
  assign dfc_start  = state == LAUNCH;
  assign idle       = state == IDLE && empty;
`ifdef DFCONV_DISPATCH_ZERO_SKIP_EN
  assign skip = pop && (head[4*WIDTH-1:3*WIDTH] == '0 || head[3*WIDTH-1:2*WIDTH] == '0 ||
                        head[2*WIDTH-1:WIDTH] == '0 || head[WIDTH-1:0] == '0);
`else
  assign skip = 1'b0;
`endif

  // Clear takes effect before any same-cycle accumulation.
  assign tot_base  = stat_clr ? '0 : total_cycles;
  assign jobs_base = stat_clr ? '0 : jobs_done;
  assign sum       = {1'b0, tot_base} + {1'b0, dfc_cycles_used};

  // Descriptor storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= {desc_rows, desc_cols, desc_in_ch, desc_out_ch};

  // Queue pointers, FSM state and the active-job field registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
      dfc_rows   <= '0;
      dfc_cols   <= '0;
      dfc_in_ch  <= '0;
      dfc_out_ch <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (pop && !skip) {dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch} <= head;
    end

  // Next-state: launch lasts one cycle, WAIT holds until the engine reports done.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (pop && !skip) ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = dfc_done ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // Statistics: saturating cycle sum and wrapping job count.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      total_cycles <= '0;
      jobs_done    <= '0;
    end else begin
      total_cycles <= acc ? (sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0]) : tot_base;
      jobs_done    <= (acc || skip) ? jobs_base + WIDTH'(1) : jobs_base;
    end
endmodule

// File: tb/tb_dfconv_dispatch.sv
// tb_dfconv_dispatch: directed vectors and corner sequences for dfconv_dispatch.
module tb_dfconv_dispatch;
  localparam int W = 16;
  localparam int A = 32;

  logic         clk = 1'b0;
  logic         rst_n, desc_valid, desc_ready, dfc_start, dfc_done, stat_clr, idle;
  logic [W-1:0] desc_rows, desc_cols, desc_in_ch, desc_out_ch;
  logic [W-1:0] dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch, jobs_done;
  logic [A-1:0] dfc_cycles_used, total_cycles;

  dfconv_dispatch dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_rows(desc_rows), .desc_cols(desc_cols), .desc_in_ch(desc_in_ch), .desc_out_ch(desc_out_ch),
    .dfc_start(dfc_start), .dfc_rows(dfc_rows), .dfc_cols(dfc_cols), .dfc_in_ch(dfc_in_ch),
    .dfc_out_ch(dfc_out_ch), .dfc_done(dfc_done), .dfc_cycles_used(dfc_cycles_used),
    .stat_clr(stat_clr), .total_cycles(total_cycles), .jobs_done(jobs_done), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, c, i, o, cost, tot, jobs;
  } vec_t;

  int           tests = 0, fails = 0, starts = 0, lat = 2;
  logic         auto_rsp = 1'b1, stall = 1'b0, man_done = 1'b0;
  logic [A-1:0] man_cost = '0;
  logic [A-1:0] costs[$];
  logic [4*W-1:0] launched[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pack(input int r, input int c, input int i, input int o);
    return {W'(r), W'(c), W'(i), W'(o)};
  endfunction

  // dfconv model: answers each launch lat cycles later with the next queued cost.
  initial begin : rsp
    logic pending;
    logic a_done;
    logic [A-1:0] a_cost;
    int cnt, ci;
    pending = 0; cnt = 0; ci = 0; a_cost = '0;
    dfc_done = 0; dfc_cycles_used = '0;
    forever begin
      @(negedge clk);
      a_done = 0;
      if (!rst_n) pending = 0;
      else if (auto_rsp && pending && !stall && cnt == 0) begin
        a_done = 1;
        a_cost = ci < costs.size() ? costs[ci] : '0;
        ci++;
        pending = 0;
      end else if (pending && cnt > 0) cnt--;
      if (dfc_start) begin
        starts++;
        launched.push_back({dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch});
        pending = auto_rsp;
        cnt = lat;
      end
      dfc_done = auto_rsp ? a_done : man_done;
      dfc_cycles_used = auto_rsp ? a_cost : man_cost;
    end
  end

  task automatic push(input int r, input int c, input int i, input int o);
    int k = 0;
    @(negedge clk);
    {desc_rows, desc_cols, desc_in_ch, desc_out_ch} = pack(r, c, i, o);
    desc_valid = 1;
    while (!desc_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!desc_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1 desc_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    while (!idle && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(idle), 64'd1);
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    @(negedge clk);
    while (!dfc_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(dfc_start), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
  endtask

  vec_t v[3];

  initial begin
    int b;
    v[0] = '{4, 4, 36, 36, 761, 761, 1};
    v[1] = '{8, 8, 36, 36, 3044, 3805, 2};
    v[2] = '{3, 5, 7, 9, 20, 3825, 3};
    rst_n = 0; desc_valid = 0; stat_clr = 0;
    {desc_rows, desc_cols, desc_in_ch, desc_out_ch} = '0;
    #12;
    check("rst_ready", 64'(desc_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_start", 64'(dfc_start), 64'd0);
    check("rst_total", 64'(total_cycles), 64'd0);
    check("rst_jobs", 64'(jobs_done), 64'd0);
    check("rst_fields", 64'({dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch}), 64'd0);
    @(negedge clk) rst_n = 1;

    // Single jobs from an idle, empty dispatcher; also checks launch latency.
    for (int n = 0; n < 3; n++) begin
      b = starts;
      costs.push_back(A'(v[n].cost));
      push(v[n].r, v[n].c, v[n].i, v[n].o);
      @(negedge clk);
      check("lat_early", 64'(dfc_start), 64'd0);
      @(negedge clk);
      check("lat_start", 64'(dfc_start), 64'd1);
      check("vec_fields", 64'({dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch}), 64'(pack(v[n].r, v[n].c, v[n].i, v[n].o)));
      wait_idle("vec_idle");
      check("vec_total", 64'(total_cycles), 64'(v[n].tot));
      check("vec_jobs", 64'(jobs_done), 64'(v[n].jobs));
      check("vec_starts", 64'(starts - b), 64'd1);
    end

    // Back-to-back pushes launch in order.
    do_reset();
    b = starts;
    costs.push_back(761); costs.push_back(3044); costs.push_back(3044);
    push(4, 4, 36, 36); push(8, 8, 36, 36); push(4, 16, 36, 36);
    wait_idle("b2b_idle");
    check("b2b_total", 64'(total_cycles), 64'd6849);
    check("b2b_jobs", 64'(jobs_done), 64'd3);
    check("b2b_starts", 64'(starts - b), 64'd3);
    check("b2b_ord0", 64'(launched[b]), 64'(pack(4, 4, 36, 36)));
    check("b2b_ord1", 64'(launched[b+1]), 64'(pack(8, 8, 36, 36)));
    check("b2b_ord2", 64'(launched[b+2]), 64'(pack(4, 16, 36, 36)));

    // Stalled engine: one active plus four queued fills the queue.
    do_reset();
    b = starts;
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      costs.push_back(A'(10 + k));
      push(k + 1, 2, 3, 4);
    end
    @(negedge clk);
    check("full_ready", 64'(desc_ready), 64'd0);
    check("full_starts", 64'(starts - b), 64'd1);
    stall = 0;
    wait_idle("full_idle");
    check("full_jobs", 64'(jobs_done), 64'd5);
    check("full_total", 64'(total_cycles), 64'd60);
    for (int k = 0; k < 5; k++) check("full_order", 64'(launched[b+k]), 64'(pack(k + 1, 2, 3, 4)));

    // Saturation of the cycle sum.
    do_reset();
    costs.push_back(32'hFFFF_FFF0);
    push(4, 4, 36, 36);
    wait_idle("sat_idle0");
    check("sat_pre", 64'(total_cycles), 64'hFFFF_FFF0);
    costs.push_back(761);
    push(4, 4, 36, 36);
    wait_idle("sat_idle1");
    check("sat_total", 64'(total_cycles), 64'hFFFF_FFFF);
    check("sat_jobs", 64'(jobs_done), 64'd2);

    // Clear coinciding with completion: clear first, then accumulate.
    @(posedge clk) #1 auto_rsp = 0;
    push(1, 1, 1, 1);
    wait_start("clr_start");
    @(posedge clk) #1;
    man_done = 1; man_cost = 3; stat_clr = 1;
    @(posedge clk) #1;
    man_done = 0; stat_clr = 0;
    @(negedge clk);
    check("clr_total", 64'(total_cycles), 64'd3);
    check("clr_jobs", 64'(jobs_done), 64'd1);
    check("clr_idle", 64'(idle), 64'd1);

    // Completion pulse while idle is ignored.
    @(posedge clk) #1;
    man_done = 1; man_cost = 100;
    @(posedge clk) #1 man_done = 0;
    @(negedge clk);
    check("stray_total", 64'(total_cycles), 64'd3);
    check("stray_jobs", 64'(jobs_done), 64'd1);

    // Reset while waiting drops the job; a late completion is ignored.
    push(2, 2, 2, 2);
    wait_start("rw_start");
    @(posedge clk) #3 rst_n = 0;
    #1;
    check("rw_total", 64'(total_cycles), 64'd0);
    check("rw_jobs", 64'(jobs_done), 64'd0);
    check("rw_start0", 64'(dfc_start), 64'd0);
    check("rw_fields", 64'({dfc_rows, dfc_cols, dfc_in_ch, dfc_out_ch}), 64'd0);
    check("rw_ready", 64'(desc_ready), 64'd1);
    check("rw_idle", 64'(idle), 64'd1);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    man_done = 1; man_cost = 50;
    @(posedge clk) #1 man_done = 0;
    @(negedge clk);
    check("late_total", 64'(total_cycles), 64'd0);
    check("late_jobs", 64'(jobs_done), 64'd0);
    check("late_idle", 64'(idle), 64'd1);
    @(posedge clk) #1 auto_rsp = 1;

    // Zero-field descriptor.
    b = starts;
`ifndef DFCONV_DISPATCH_ZERO_SKIP_EN
    costs.push_back(500);
`endif
    push(0, 4, 36, 36);
    wait_idle("zero_idle");
    check("zero_jobs", 64'(jobs_done), 64'd1);
`ifdef DFCONV_DISPATCH_ZERO_SKIP_EN
    check("zero_starts", 64'(starts - b), 64'd0);
    check("zero_total", 64'(total_cycles), 64'd0);
`else
    check("zero_starts", 64'(starts - b), 64'd1);
    check("zero_total", 64'(total_cycles), 64'd500);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
